join_neuron: RTL and testbench

Clocked join element: merges `N_IN` four-phase bundled-data input channels into a single four-phase output channel. The output request carries the concatenated data of all channels. The output token is issued only once every input has delivered one token. This is the converging counterpart of the fork element in the spike-routing fabric, placed where parallel branches recombine before a neuron or a downstream pipeline stage. Input acknowledges behave like a C-element join: no input handshake completes until the output handshake has fully returned to zero.

---
 rtl/join_neuron_pkg.sv | 13 +
 rtl/join_neuron_sync.sv | 26 ++
 rtl/join_neuron.sv | 121 ++++++++++++
 tb/tb_join_neuron.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/join_neuron_pkg.sv
// Shared types for the join_neuron element: FSM state encoding and synchronizer depth.
// Used by join_neuron in both the synchronized (JOIN_NEURON_SYNC_EN) and direct builds.
package join_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      SEND    = 2'd1,
      RTZ     = 2'd2
   } join_state_t;

   localparam int SYNC_STAGES = 2;

endpackage : join_pkg

// File: rtl/join_neuron_sync.sv
// One-bit two-flop synchronizer for handshake lines entering the join_neuron clock domain.
// Used by join_neuron only when JOIN_NEURON_SYNC_EN is defined.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule : sync_2ff

// File: rtl/join_neuron.sv
// Four-phase bundled-data join: collects one token from each of N_IN inputs, then emits one
// concatenated token. Define JOIN_NEURON_SYNC_EN to synchronize req_in/ack_out through 2 flops.
module join_neuron
   import join_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_IN-1:0]          req_in,
   input  logic [N_IN*DATA_W-1:0]   data_in,
   output logic [N_IN-1:0]          ack_in,
   output logic                     req_out,
   output logic [N_IN*DATA_W-1:0]   data_out,
   input  logic                     ack_out
);

   logic [N_IN-1:0] s_req;
   logic            s_ack;

`ifdef JOIN_NEURON_SYNC_EN
   for (genvar g = 0; g < N_IN; g++) begin : g_req_sync
      sync_2ff u_sync_req (
         .clk   (clk),
         .rst_n (rst),
         .d     (req_in[g]),
         .q     (s_req[g])
      );
   end

   sync_2ff u_sync_ack (
      .clk   (clk),
      .rst_n (rst),
      .d     (ack_out),
      .q     (s_ack)
   );
`else
   assign s_req = req_in;
   assign s_ack = ack_out;
`endif

   join_state_t               state_q,    state_d;
   logic [N_IN-1:0]           flag_q,     flag_d;
   logic [N_IN-1:0]           ack_in_q,   ack_in_d;
   logic                      req_out_q,  req_out_d;
   logic [N_IN*DATA_W-1:0]    data_out_q, data_out_d;
   logic [N_IN-1:0]           capture;

   // NOTE: every signal gets a default at the top so no path through the case infers a latch.
   always_comb begin
      state_d    = state_q;
      flag_d     = flag_q;
      ack_in_d   = ack_in_q;
      req_out_d  = req_out_q;
      data_out_d = data_out_q;
      capture    = '0;

      case (state_q)
         COLLECT: begin
            // A channel that already holds its token ignores a still-high request.
            capture  = s_req & ~flag_q;
            flag_d   = flag_q | capture;
            ack_in_d = ack_in_q | capture;
            for (int i = 0; i < N_IN; i++) begin
               if (capture[i]) begin
                  data_out_d[i*DATA_W +: DATA_W] = data_in[i*DATA_W +: DATA_W];
               end
            end
            if (&flag_d) begin
               req_out_d = 1'b1;
               state_d   = SEND;
            end
         end

         SEND: begin
            if (s_ack) begin
               req_out_d = 1'b0;
               state_d   = RTZ;
            end
         end

         RTZ: begin
            // Both sides must be back to zero on the same edge before acks drop.
            if (!s_ack && (s_req == '0)) begin
               flag_d   = '0;
               ack_in_d = '0;
               state_d  = COLLECT;
            end
         end

         default: begin
            state_d   = COLLECT;
            flag_d    = '0;
            ack_in_d  = '0;
            req_out_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= COLLECT;
         flag_q     <= '0;
         ack_in_q   <= '0;
         req_out_q  <= 1'b0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         flag_q     <= flag_d;
         ack_in_q   <= ack_in_d;
         req_out_q  <= req_out_d;
         data_out_q <= data_out_d;
      end
   end

   assign ack_in   = ack_in_q;
   assign req_out  = req_out_q;
   assign data_out = data_out_q;

endmodule : join_neuron

// File: tb/tb_join_neuron.sv
// Directed bench for join_neuron (N_IN=2, DATA_W=8); expected latencies follow JOIN_NEURON_SYNC_EN.
module tb_join_neuron;

   localparam int N_IN   = 2;
   localparam int DATA_W = 8;
`ifdef JOIN_NEURON_SYNC_EN
   localparam int S = 2;
`else
   localparam int S = 0;
`endif
   localparam int LIMIT = 40;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic [N_IN-1:0]        req_in = '0;
   logic [N_IN*DATA_W-1:0] data_in = '0;
   logic [N_IN-1:0]        ack_in;
   logic                   req_out;
   logic [N_IN*DATA_W-1:0] data_out;
   logic                   ack_out = 1'b0;

   int total = 0;
   int bad   = 0;
   int n;

   always #5 clk = ~clk;

   join_neuron #(.N_IN(N_IN), .DATA_W(DATA_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_in   (req_in),
      .data_in  (data_in),
      .ack_in   (ack_in),
      .req_out  (req_out),
      .data_out (data_out),
      .ack_out  (ack_out)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_ack(input logic [N_IN-1:0] val, output int cnt);
      cnt = 0;
      while (ack_in !== val && cnt < LIMIT) begin
         step(1);
         cnt++;
      end
   endtask

   task automatic wait_req_out(input logic val, output int cnt);
      cnt = 0;
      while (req_out !== val && cnt < LIMIT) begin
         step(1);
         cnt++;
      end
   endtask

   initial begin
      // Reset with random inputs toggling
      for (int i = 0; i < 4; i++) begin
         req_in  = N_IN'($urandom);
         data_in = (N_IN*DATA_W)'($urandom);
         ack_out = 1'($urandom);
         step(1);
      end
      check("rst_ack_in",   32'(ack_in),   32'h0);
      check("rst_req_out",  32'(req_out),  32'h0);
      check("rst_data_out", 32'(data_out), 32'h0);
      req_in  = '0;
      ack_out = 1'b0;
      data_in = '0;
      step(1);
      rst = 1'b1;
      step(4);
      check("idle_ack_in",  32'(ack_in),  32'h0);
      check("idle_req_out", 32'(req_out), 32'h0);

      // Staggered capture
      req_in[0] = 1'b1;
      data_in[7:0] = 8'h12;
      wait_ack(2'b01, n);
      check("lat_req_to_ack", 32'(n), 32'(S + 1));
      check("stag_req_out_low", 32'(req_out), 32'h0);
      step(4);
      req_in[1] = 1'b1;
      data_in[15:8] = 8'h34;
      wait_ack(2'b11, n);
      check("stag_ack1_lat", 32'(n), 32'(S + 1));
      check("stag_req_out", 32'(req_out), 32'h1);
      check("stag_data", 32'(data_out), 32'h3412);
      ack_out = 1'b1;
      wait_req_out(1'b0, n);
      check("lat_ack_to_req_fall", 32'(n), 32'(S + 1));
      ack_out = 1'b0;
      req_in  = '0;
      wait_ack(2'b00, n);
      check("stag_rtz_lat", 32'(n), 32'(S + 1));

      // Protocol violation: ack_out pulse outside SEND does nothing
      ack_out = 1'b1;
      step(S + 2);
      ack_out = 1'b0;
      step(S + 2);
      check("viol_req_out", 32'(req_out), 32'h0);
      check("viol_ack_in",  32'(ack_in),  32'h0);

      // Simultaneous capture
      req_in  = 2'b11;
      data_in = 16'h55AA;
      step(S);
      check("sim_ack_early", 32'(ack_in), 32'h0);
      step(1);
      check("sim_ack",     32'(ack_in),   32'h3);
      check("sim_req_out", 32'(req_out),  32'h1);
      check("sim_data",    32'(data_out), 32'h55AA);
      ack_out = 1'b1;
      wait_req_out(1'b0, n);
      check("sim_req_fall", 32'(n), 32'(S + 1));
      ack_out = 1'b0;
      req_in  = '0;
      wait_ack(2'b00, n);
      check("sim_rtz", 32'(n), 32'(S + 1));

      // Early drop on ch0, stuck request on ch1
      req_in  = 2'b11;
      data_in = 16'h0FF0;
      wait_ack(2'b11, n);
      check("stuck_cap", 32'(n), 32'(S + 1));
      req_in[0] = 1'b0;
      ack_out = 1'b1;
      wait_req_out(1'b0, n);
      check("stuck_req_fall", 32'(n), 32'(S + 1));
      ack_out = 1'b0;
      data_in = 16'h7777;
      step(6);
      check("stuck_ack_hold", 32'(ack_in),   32'h3);
      check("stuck_req_out",  32'(req_out),  32'h0);
      check("stuck_data",     32'(data_out), 32'h0FF0);
      req_in[1] = 1'b0;
      step(S);
      check("stuck_ack_before", 32'(ack_in), 32'h3);
      step(1);
      check("stuck_ack_fall", 32'(ack_in),   32'h0);
      check("stuck_norecap",  32'(data_out), 32'h0FF0);

      // Mid-operation reset while in SEND
      req_in  = 2'b11;
      data_in = 16'hBEEF;
      wait_req_out(1'b1, n);
      check("mrst_send", 32'(n), 32'(S + 1));
      #2;
      rst = 1'b0;
      #1;
      check("mrst_req_out",  32'(req_out),  32'h0);
      check("mrst_ack_in",   32'(ack_in),   32'h0);
      check("mrst_data_out", 32'(data_out), 32'h0);
      req_in = '0;
      step(2);
      rst = 1'b1;
      step(2);
      req_in  = 2'b11;
      data_in = 16'h9C3B;
      wait_req_out(1'b1, n);
      check("fresh_lat",  32'(n),        32'(S + 1));
      check("fresh_ack",  32'(ack_in),   32'h3);
      check("fresh_data", 32'(data_out), 32'h9C3B);
      ack_out = 1'b1;
      wait_req_out(1'b0, n);
      check("fresh_req_fall", 32'(n), 32'(S + 1));
      ack_out = 1'b0;
      req_in  = '0;
      wait_ack(2'b00, n);
      check("fresh_rtz", 32'(n), 32'(S + 1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_join_neuron
